// File: rtl/dct_pkg.sv
// Shared DCT controller types and constants.
// Used by the stage-1 and stage-2 sequencing controllers.
package dct_pkg;

  localparam int DCT_N    = 8;
  localparam int DCT_IDXW = 3;

  typedef enum logic {
    FILL = 1'b0,
    READ = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/dct_stage2_col_ctrl_if.sv
// Handshake and bank-control bundle between stage 1,
// the stage-2 column controller and the stage-2 datapath.
interface dct_stage2_col_ctrl_if #(
  parameter int NCOL = 8,
  parameter int CW   = 3
);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [NCOL-1:0] col_wr_en;
  logic [CW-1:0]   col_idx;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   rd_sel;
  logic            out_last;
  logic            blk_done;
  logic [15:0]     blk_cnt;

  modport slave (
    input  flush,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output col_wr_en,
    output col_idx,
    output out_valid,
    output rd_sel,
    output out_last,
    output blk_done,
    output blk_cnt
  );

  modport master (
    output flush,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  col_wr_en,
    input  col_idx,
    input  out_valid,
    input  rd_sel,
    input  out_last,
    input  blk_done,
    input  blk_cnt
  );

endinterface

// File: rtl/dct_idx_counter.sv
// Modulo-N index counter with enable and synchronous clear.
// wrap flags the enabled step from N-1 back to 0.
module dct_idx_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         wrap
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  always_comb begin
    wrap  = en && (idx_q == W'(N - 1));
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/dct_stage2_col_ctrl.sv
// Stage-2 column bank controller: fills an 8x8 block
// column by column, then replays it row by row.
module dct_stage2_col_ctrl
  import dct_pkg::*;
#(
  parameter int NCOL = DCT_N,
  parameter int NROW = DCT_N,
  parameter int CW   = DCT_IDXW
) (
  input  logic                 clk,
  input  logic                 rst,
  dct_stage2_col_ctrl_if.slave bus
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic        blk_done_q;
  logic        blk_done_d;
  logic [15:0] blk_cnt_q;
  logic [15:0] blk_cnt_d;

  logic          in_fill;
  logic          in_read;
  logic          accept;
  logic          row_hs;
  logic [CW-1:0] col_idx;
  logic [CW-1:0] row_idx;
  logic          col_wrap;
  logic          row_wrap;

  assign in_fill = (state_q == FILL);
  assign in_read = (state_q == READ);

  // Gate ready with the reset pin so nothing is written while held.
  assign accept = in_fill && rst && bus.in_valid && !bus.flush;
  assign row_hs = in_read && bus.out_ready && !bus.flush;

  dct_idx_counter #(
    .N (NCOL),
    .W (CW)
  ) u_col_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flush),
    .en   (accept),
    .idx  (col_idx),
    .wrap (col_wrap)
  );

  dct_idx_counter #(
    .N (NROW),
    .W (CW)
  ) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flush),
    .en   (row_hs),
    .idx  (row_idx),
    .wrap (row_wrap)
  );

  always_comb begin
    state_d    = state_q;
    blk_done_d = 1'b0;
    blk_cnt_d  = blk_cnt_q;
    unique case (1'b1)
      bus.flush: begin
        state_d = FILL;
      end
      col_wrap: begin
        state_d = READ;
      end
      row_wrap: begin
        state_d    = FILL;
        blk_done_d = 1'b1;
        blk_cnt_d  = blk_cnt_q + 16'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      blk_done_q <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      blk_done_q <= blk_done_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign bus.in_ready  = in_fill && rst;
  assign bus.col_wr_en = accept ? (NCOL'(1) << col_idx) : '0;
  assign bus.col_idx   = col_idx;
  assign bus.out_valid = in_read;
  assign bus.rd_sel    = in_read ? row_idx : '0;
  assign bus.out_last  = in_read && (row_idx == CW'(NROW - 1));
  assign bus.blk_done  = blk_done_q;
  assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: doc/dct_stage2_col_ctrl.md
# dct_stage2_col_ctrl

Write-sequencing and readout controller for the DCT stage-2 column register banks. It accepts one 8-element column vector per handshake from stage 1, steers a one-hot write enable to the matching column bank so the 8×8 block is assembled column by column, then replays the block row by row to the stage-2 datapath through a row-select index. It sits between the stage-1 output and the stage-2 transpose/compute path, and owns all `wr_en` inputs of the column banks.

## Interface
- `NCOL`, 8, number of column banks (columns per block)
- `NROW`, 8, number of rows replayed per block
- `CW`, 3, width of column/row indices, equal to $clog2(NCOL)
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  reset, asynchronous, active-low (asserted when 0)
- `flush`  input  1  synchronous abort of the current block, active-high
- `in_valid`  input  1  stage 1 presents a column vector
- `in_ready`  output  1  controller can accept a column this cycle
- `col_wr_en`  output  NCOL  one-hot write enable to column banks, bit i drives bank i `wr_en`
- `col_idx`  output  CW  index of the next column to be written
- `out_valid`  output  1  row `rd_sel` of a complete block is presented to stage 2
- `out_ready`  input  1  stage 2 consumes the presented row
- `rd_sel`  output  CW  row index for the bank read mux
- `out_last`  output  1  presented row is the final row (rd_sel == NROW-1)
- `blk_done`  output  1  one-cycle pulse after the last row handshake
- `blk_cnt`  output  16  count of fully replayed blocks, wraps modulo 2^16

## Operation
- States: FILL, READ. Reset state FILL.
- FILL: `in_ready`=1, `out_valid`=0. An accept is `in_valid && in_ready && !flush`. On an accept, `col_wr_en` = 1 << col_idx in the same cycle (combinational), and col_idx increments. An accept at col_idx == NCOL-1 sets col_idx to 0 and moves to READ.
- READ: `in_ready`=0, `col_wr_en`=0, `out_valid`=1, `rd_sel`=row_idx, `out_last`=(row_idx==NROW-1). A row handshake is `out_valid && out_ready && !flush`, and row_idx increments on it. The handshake with `out_last` high sets row_idx to 0, moves to FILL, pulses `blk_done` on the next cycle and increments `blk_cnt`.
- `flush` has the highest priority in every state. It forces FILL, clears col_idx and row_idx, gates `col_wr_en` to 0 in that cycle, and suppresses `blk_done` and the `blk_cnt` increment. Bank contents are not cleared; they are overwritten by the next fill.
- `col_wr_en` is never anything other than all-zero or one-hot. It is never asserted in READ.
- `out_valid`, `rd_sel` and `out_last` are held stable while `out_valid && !out_ready`.
- Indices are unsigned CW-bit values and never exceed NCOL-1 or NROW-1.

## Timing
- Reset (rst=0, asynchronous): state=FILL, col_idx=0, row_idx=0, `col_wr_en`=0, `out_valid`=0, `out_last`=0, `rd_sel`=0, `blk_done`=0, `blk_cnt`=0, `in_ready`=1 once out of reset. Reset asserted mid-block discards the block immediately.
- Write latency: a column is captured by its bank on the same clock edge as its accept.
- Fill-to-read: first `out_valid` appears on the cycle after the 8th accept, so the bank data is already registered.
- Minimum block period is NCOL + NROW = 16 cycles with `in_valid` and `out_ready` held high. There is no overlap: single buffering.
- `blk_done` is registered, high for exactly one cycle, in the first FILL cycle after the last row.
- Simultaneous `flush` and a last-row handshake: flush wins, with no `blk_done` and no count.

## Structure
- Shared package `dct_pkg`: state enum `ctrl_state_t` {FILL, READ}, and constants `DCT_N`=8 and `DCT_IDXW`=3, reused by the stage-1 and stage-2 controllers.
- One natural sub-module, `dct_idx_counter`: a modulo-N index counter with enable and synchronous clear, instantiated twice (column and row).
- Column bank datapath stays external; only `col_wr_en` and `rd_sel` cross the boundary.

## Test plan
- Reset then 8 back-to-back `in_valid` -> `col_wr_en` = 0x01, 0x02, …, 0x80 on successive cycles; `out_valid` rises on cycle 9 with `rd_sel`=0.
- `out_ready`=1 for 8 cycles -> `rd_sel` 0..7, `out_last` only at 7, `blk_done` single pulse next cycle, `blk_cnt`=1, `in_ready`=1.
- `in_valid` gaps (pattern 1,0,0,1,…) and `out_ready` stalls -> col_idx and rd_sel advance only on handshakes; outputs held during stalls; no write in READ even with `in_valid`=1.
- `flush` after 5 columns accepted -> `col_wr_en`=0 that cycle, next accept writes bank 0; `flush` coincident with the last-row handshake -> no `blk_done`, `blk_cnt` unchanged.
- `rst` pulled low during READ at row 3 -> all outputs at reset values asynchronously; after release, the first accept drives `col_wr_en`=0x01.
- 65537 complete blocks -> `blk_cnt` wraps to 1.
